// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN sequencer: FSM encoding, layer codes
// and the default network dimensions.
package bnn_pkg;

  localparam int N_IN     = 16;
  localparam int N_HID    = 4;
  localparam int N_OUT    = 4;
  localparam int SCORE_W  = 5;
  localparam int HID_THR  = 8;
  localparam int CLS_W    = 3;
  localparam int HID_IDX_W = $clog2(N_HID);

  localparam logic LAYER_HID = 1'b0;
  localparam logic LAYER_OUT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bnn_argmax_tracker.sv
// Running argmax over the output-layer scores. Strict greater-than keeps the
// lowest index on ties; the first score after clear always loads.
module bnn_argmax_tracker
  import bnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic               valid,
  input  logic [CLS_W-1:0]   idx,
  input  logic [SCORE_W-1:0] score,
  output logic [CLS_W-1:0]   max_idx,
  output logic [SCORE_W-1:0] max_score
);

  logic loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded    <= 1'b0;
      max_idx   <= '0;
      max_score <= '0;
    end else if (en) begin
      if (clear) begin
        loaded    <= 1'b0;
        max_idx   <= '0;
        max_score <= '0;
      end else if (valid && (!loaded || score > max_score)) begin
        loaded    <= 1'b1;
        max_idx   <= idx;
        max_score <= score;
      end
    end
  end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Sequencer for the BNN: captures one feature vector per request and walks the
// shared XNOR-popcount datapath over the hidden, then the output neurons.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; datapath request idle
// ST_HID  | requesting hidden neuron dp_idx on the captured features
// ST_OUT  | requesting output neuron dp_idx on the hidden activations
// ST_DONE | one-cycle done pulse; class_out loads the argmax result
module bnn_seq_ctrl
  import bnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [N_IN-1:0]    features_in,
  output logic               busy,
  output logic               done,
  output logic [CLS_W-1:0]   class_out,
  output logic [N_HID-1:0]   hidden_act,
  output logic [1:0]         state_out,
  output logic               dp_valid,
  output logic               dp_layer,
  output logic [CLS_W-1:0]   dp_idx,
  output logic [N_IN-1:0]    dp_vec,
  input  logic               dp_ready,
  input  logic [SCORE_W-1:0] dp_score
);

  state_e             state;
  logic [N_HID-1:0]   hid_nxt;
  logic [CLS_W-1:0]   arg_idx;
  logic [SCORE_W-1:0] arg_score;
  logic               arg_clear;
  logic               arg_valid;

  assign state_out = state;
  assign arg_clear = (state == ST_IDLE) && start;
  assign arg_valid = (state == ST_OUT) && dp_ready;

  // Activations including the neuron being accepted this cycle, so the
  // output-layer operand sees the final hidden vector on its first request.
  always_comb begin
    hid_nxt = hidden_act;
    hid_nxt[dp_idx[HID_IDX_W-1:0]] = (dp_score >= SCORE_W'(HID_THR));
  end

  bnn_argmax_tracker u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (ena),
    .clear     (arg_clear),
    .valid     (arg_valid),
    .idx       (dp_idx),
    .score     (dp_score),
    .max_idx   (arg_idx),
    .max_score (arg_score)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      class_out  <= '0;
      hidden_act <= '0;
      dp_valid   <= 1'b0;
      dp_layer   <= LAYER_HID;
      dp_idx     <= '0;
      dp_vec     <= '0;
    end else if (ena) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_HID;
            busy     <= 1'b1;
            dp_valid <= 1'b1;
            dp_layer <= LAYER_HID;
            dp_idx   <= '0;
            dp_vec   <= features_in;
          end
        end
        ST_HID: begin
          if (dp_ready) begin
            hidden_act <= hid_nxt;
            if (dp_idx == CLS_W'(N_HID - 1)) begin
              state    <= ST_OUT;
              dp_layer <= LAYER_OUT;
              dp_idx   <= '0;
              dp_vec   <= N_IN'(hid_nxt);
            end else begin
              dp_idx <= dp_idx + CLS_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (dp_ready) begin
            if (dp_idx == CLS_W'(N_OUT - 1)) begin
              state    <= ST_DONE;
              dp_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              dp_idx <= dp_idx + CLS_W'(1);
            end
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          // an all-zero score set resolves to class 0
          class_out <= (arg_score == '0) ? '0 : arg_idx;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Self-checking bench for bnn_seq_ctrl: directed scenarios plus randomized
// runs checked against a score-table reference model.
module tb_bnn_seq_ctrl;
  import bnn_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ena = 1'b1;
  logic               start = 1'b0;
  logic [N_IN-1:0]    features_in = '0;
  logic               busy, done, dp_valid, dp_layer;
  logic [CLS_W-1:0]   class_out, dp_idx;
  logic [N_HID-1:0]   hidden_act;
  logic [1:0]         state_out;
  logic [N_IN-1:0]    dp_vec;
  logic               dp_ready = 1'b0;
  logic [SCORE_W-1:0] dp_score;

  int hid_s[N_HID];
  int out_s[N_OUT];
  bit rdy_pat[64];
  int checks = 0;
  int errors = 0;

  bnn_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .features_in(features_in),
    .busy(busy), .done(done), .class_out(class_out), .hidden_act(hidden_act),
    .state_out(state_out), .dp_valid(dp_valid), .dp_layer(dp_layer), .dp_idx(dp_idx),
    .dp_vec(dp_vec), .dp_ready(dp_ready), .dp_score(dp_score)
  );

  always #5 clk = ~clk;

  // datapath model: score looked up from the current test's tables
  always_comb begin
    dp_score = '0;
    if (dp_layer) dp_score = SCORE_W'(out_s[dp_idx[1:0]]);
    else          dp_score = SCORE_W'(hid_s[dp_idx[1:0]]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_HID-1:0] ref_act();
    logic [N_HID-1:0] r;
    for (int i = 0; i < N_HID; i++) r[i] = (hid_s[i] >= HID_THR);
    return r;
  endfunction

  function automatic int ref_cls();
    int best = 0;
    for (int i = 1; i < N_OUT; i++) if (out_s[i] > out_s[best]) best = i;
    return best;
  endfunction

  // One request; restart_c re-pulses start (with alt features) at that cycle.
  task automatic do_run(input logic [N_IN-1:0] feat, input int restart_c,
                        input logic [N_IN-1:0] alt);
    logic [N_HID-1:0] exp_act;
    int exp_cls, exp_done, acc;
    exp_act  = ref_act();
    exp_cls  = ref_cls();
    exp_done = 0;
    acc      = 0;
    for (int c = 1; c < 64; c++) begin
      if (rdy_pat[c]) acc++;
      if (acc == N_HID + N_OUT) begin
        exp_done = c + 1;
        break;
      end
    end
    features_in = feat;
    start       = 1'b1;
    dp_ready    = rdy_pat[0];
    tick();
    acc = 0;
    for (int c = 1; c <= exp_done; c++) begin
      dp_ready = rdy_pat[c];
      if (c == restart_c) begin
        start       = 1'b1;
        features_in = alt;
      end else begin
        start       = 1'b0;
        features_in = N_IN'($urandom);
      end
      if (c < exp_done) begin
        chk("busy_run", busy, 1);
        chk("done_early", done, 0);
        chk("dp_valid_run", dp_valid, 1);
        chk("dp_layer", dp_layer, (acc >= N_HID) ? 1 : 0);
        chk("dp_idx", dp_idx, acc % N_HID);
        chk("dp_vec", dp_vec, (acc < N_HID) ? feat : N_IN'(exp_act));
        chk("state_run", state_out, (acc < N_HID) ? 1 : 2);
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        chk("dp_valid_done", dp_valid, 0);
        chk("state_done", state_out, 3);
      end
      if (rdy_pat[c]) acc++;
      tick();
    end
    start = 1'b0;
    chk("done_fall", done, 0);
    chk("busy_idle", busy, 0);
    chk("state_idle", state_out, 0);
    chk("class_out", class_out, exp_cls);
    chk("hidden_act", hidden_act, exp_act);
  endtask

  task automatic set_rdy_all();
    for (int c = 0; c < 64; c++) rdy_pat[c] = 1'b1;
  endtask

  initial begin
    // reset values
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_class", class_out, 0);
    chk("rst_hidden", hidden_act, 0);
    chk("rst_state", state_out, 0);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_dp_layer", dp_layer, 0);
    chk("rst_dp_idx", dp_idx, 0);
    chk("rst_dp_vec", dp_vec, 0);
    rst_n = 1'b1;
    tick();

    // basic run, ready tied high: done at cycle 9
    hid_s = '{9, 7, 8, 3};
    out_s = '{2, 6, 6, 1};
    set_rdy_all();
    do_run(16'hFFFF, -1, '0);

    // 3-cycle stall while at hidden idx 2: done at cycle 12
    rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b0;
    do_run(16'hFFFF, -1, '0);

    // argmax boundaries
    set_rdy_all();
    out_s = '{0, 0, 0, 0};
    do_run(16'h1357, -1, '0);
    out_s = '{1, 1, 1, 4};
    do_run(16'h2468, -1, '0);

    // start re-pulsed while busy, and again in the DONE cycle
    hid_s = '{9, 7, 8, 3};
    out_s = '{2, 6, 6, 1};
    do_run(16'h0F0F, 4, 16'hF0F0);
    do_run(16'h3C3C, 9, 16'hC3C3);

    // ena low for two OUT cycles and across DONE
    dp_ready    = 1'b1;
    features_in = 16'h1234;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      ena = !(c == 6 || c == 7 || c == 11 || c == 12);
      if (c >= 6 && c <= 8) begin
        chk("ena_state_frz", state_out, 2);
        chk("ena_idx_frz", dp_idx, 1);
      end
      if (c == 10) begin
        chk("ena_idx3", dp_idx, 3);
        chk("ena_done_lo", done, 0);
      end
      if (c >= 11 && c <= 13) chk("ena_done_hold", done, 1);
      if (c == 14) begin
        chk("ena_done_fall", done, 0);
        chk("ena_class", class_out, 1);
        chk("ena_busy", busy, 0);
      end
      tick();
    end
    ena = 1'b1;

    // asynchronous reset mid-HID
    features_in = 16'hA5A5;
    start       = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_dp_valid", dp_valid, 0);
    chk("arst_hidden", hidden_act, 0);
    chk("arst_state", state_out, 0);
    chk("arst_class", class_out, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_done", done, 0);
      chk("arst_idle", state_out, 0);
    end
    do_run(16'h5A5A, -1, '0);

    // randomized runs
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < N_HID; i++) hid_s[i] = $urandom_range(0, N_IN);
      for (int i = 0; i < N_OUT; i++) out_s[i] = (r % 3 == 0) ? $urandom_range(0, 3)
                                                               : $urandom_range(0, N_IN);
      for (int c = 0; c < 64; c++) rdy_pat[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      do_run(N_IN'($urandom), (r % 2 == 1) ? int'($urandom_range(1, 12)) : -1,
             N_IN'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_seq_ctrl.md
Name: bnn_seq_ctrl

Overview:
Sequencer for the microgreen BNN. It captures one binarized feature vector per request and time-multiplexes a single shared XNOR-popcount datapath: first over the hidden neurons, then over the output neurons. Hidden scores are thresholded into activations; output scores feed a running argmax. The block sits between the pad-level top (ui_in/uio_in feature mapping, uo_out status) and the popcount unit.

Parameters:
N_IN, 16, input vector width (4 features x 4 bits, binarized)
N_HID, 4, hidden neurons
N_OUT, 4, output classes (max 8)
SCORE_W, 5, popcount width (holds 0..N_IN)
HID_THR, 8, hidden neuron fires when score >= HID_THR

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state
start  in  1  request pulse; sampled only in IDLE
features_in  in  N_IN  binarized feature vector, captured on accepted start
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
class_out  out  3  winning class index
hidden_act  out  N_HID  hidden activations of last run
state_out  out  2  FSM state for debug
dp_valid  out  1  operand request to the datapath
dp_layer  out  1  0 = hidden layer, 1 = output layer
dp_idx  out  3  neuron index within the layer
dp_vec  out  N_IN  operand: captured features (hidden) or hidden_act zero-extended (output)
dp_ready  in  1  datapath accepts; dp_score valid in the same cycle
dp_score  in  SCORE_W  popcount result for the current operand

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: busy=0, done=0, class_out=0, hidden_act=0, state_out=IDLE(0), dp_valid=0, dp_layer=0, dp_idx=0, dp_vec=0.
- FSM states: IDLE(0), HID(1), OUT(2), DONE(3).
- IDLE: start=1 and ena=1 captures features_in, clears idx and argmax, sets busy, and moves to HID.
- HID: dp_valid=1, dp_layer=0, dp_idx=idx.
  - On dp_ready: hidden_act[idx] <= (dp_score >= HID_THR).
  - If idx==N_HID-1, move to OUT with idx=0; otherwise idx+1.
- OUT: dp_valid=1, dp_layer=1, dp_vec reflects the final hidden_act.
  - On dp_ready: argmax update.
  - If idx==N_OUT-1, move to DONE; otherwise idx+1.
- DONE: done=1 for exactly one cycle; class_out <= final argmax index; busy=0; return to IDLE.
- Handshake:
  - dp_valid, dp_layer, dp_idx and dp_vec stay stable until dp_ready is sampled high.
  - dp_valid drops in DONE and IDLE.
  - dp_ready while dp_valid=0 is ignored.
- Latency: with dp_ready tied high, start accepted at cycle 0 gives done at cycle 1+N_HID+N_OUT (cycle 9 for defaults). Each dp_ready stall cycle adds one cycle.
- Argmax:
  - A strict greater-than comparison updates the maximum, so the lowest index wins ties.
  - An all-zero score set gives class 0.
  - The first output score always loads the maximum.
- ena=0 freezes every register, including the done pulse (it extends until the next ena=1 cycle). dp_valid holds its current value; the datapath must not be given a new acceptance.
- start while busy: ignored; features_in is not recaptured.
- start in the DONE cycle: ignored. Back-to-back runs need start in IDLE, so the minimum period is N_HID+N_OUT+2 cycles.
- class_out and hidden_act hold their last values until overwritten by a later run. hidden_act is progressively overwritten during HID.
- Reset mid-run: immediate return to IDLE with the reset values; no done pulse.

Decomposition:
- Package bnn_pkg:
  - state enum (IDLE/HID/OUT/DONE)
  - layer constants (LAYER_HID=0, LAYER_OUT=1)
  - default N_IN/N_HID/N_OUT/SCORE_W/HID_THR
  - CLS_W=3
- Sub-module bnn_argmax_tracker: clear, valid, idx, score inputs; max_idx and max_score outputs; strict-greater update.

Test Plan:
- Reset, then start with features_in=16'hFFFF and dp_ready=1; datapath model returns hidden scores {9,7,8,3} and output scores {2,6,6,1}. Required: hidden_act=4'b0101, class_out=1, done pulse at cycle 9, busy high cycles 1-8.
- Same run with dp_ready low for 3 cycles while in HID idx 2. Required: dp_idx=2 and dp_vec stable throughout the stall; done at cycle 12.
- All output scores 0. Required: class_out=0. Output scores {1,1,1,4}. Required: class_out=3.
- start re-pulsed at cycle 4 with a different features_in. Required: dp_vec unchanged, one done only, results from the first vector.
- ena=0 for 2 cycles during OUT, and ena=0 during DONE. Required: state_out and dp_idx frozen during OUT; done stays high until ena returns, then falls after one cycle.
- rst_n asserted asynchronously mid-HID (between clock edges). Required: busy, dp_valid and hidden_act are 0 immediately; no done pulse; a new start afterwards runs normally.
